// File: rtl/div16s_seq_if.sv
// rtl/div16s_seq_if.sv - start/busy/done operand and result bundle for div16s_seq
interface div16s_seq_if #(
    parameter int N = 8
);
    logic                  start;
    logic signed [2*N-1:0] a;
    logic signed [N-1:0]   b;
    logic signed [N-1:0]   q;
    logic signed [N-1:0]   r;
    logic                  busy;
    logic                  done;
    logic                  ovf;
    logic                  dbz;

    modport master (
        output start, a, b,
        input  q, r, busy, done, ovf, dbz
    );

    modport slave (
        input  start, a, b,
        output q, r, busy, done, ovf, dbz
    );
endinterface

// File: rtl/div16s_seq.sv
// rtl/div16s_seq.sv - sequential 2N/N signed restoring divider, one quotient bit per clock
module div16s_seq #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    div16s_seq_if.slave  bus
);
    localparam int W  = 2 * N;
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    dvd_q, dvd_d;      // dividend magnitude, becomes quotient magnitude
    logic [N-1:0]    rem_q, rem_d;      // partial remainder, always < |b| <= 2^(N-1)
    logic [N:0]      babs_q, babs_d;    // |b|, one extra bit so -2^(N-1) is representable
    logic [CW-1:0]   count_q, count_d;
    logic            sa_q, sa_d;
    logic            sb_q, sb_d;
    logic            zdiv_q, zdiv_d;    // divide-by-zero seen at accept, resolved in FIX
    logic [N-1:0]    q_q, q_d;
    logic [N-1:0]    r_q, r_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            ovf_q, ovf_d;
    logic            dbz_q, dbz_d;

    logic [W-1:0]    a_raw;
    logic [W-1:0]    a_mag;
    logic [N:0]      b_ext;
    logic [N:0]      b_mag;
    logic [N:0]      shifted;
    logic [N+1:0]    diff;
    logic            q_neg;
    logic [W-1:0]    q_limit;
    logic            q_ovf;
    logic [W-1:0]    dvd_neg;
    logic [N-1:0]    rem_neg;

    // Operand magnitudes, trial subtraction and sign-fix helpers
    always_comb begin
        a_raw   = bus.a;
        a_mag   = a_raw[W-1] ? (~a_raw + 1'b1) : a_raw;
        b_ext   = {bus.b[N-1], bus.b};
        b_mag   = b_ext[N] ? (~b_ext + 1'b1) : b_ext;
        shifted = {rem_q, dvd_q[W-1]};
        diff    = {1'b0, shifted} - {1'b0, babs_q};
        q_neg   = sa_q ^ sb_q;
        // a negative quotient may reach one further than a positive one
        q_limit = q_neg ? (W'(1) << (N - 1)) : ((W'(1) << (N - 1)) - W'(1));
        q_ovf   = dvd_q > q_limit;
        dvd_neg = ~dvd_q + 1'b1;
        rem_neg = ~rem_q + 1'b1;
    end

    // Next-state and next-output logic for IDLE -> CALC -> FIX
    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        rem_d   = rem_q;
        babs_d  = babs_q;
        count_d = count_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        zdiv_d  = zdiv_q;
        q_d     = q_q;
        r_d     = r_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q;
        dbz_d   = dbz_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sa_d    = a_raw[W-1];
                    sb_d    = bus.b[N-1];
                    dvd_d   = a_mag;
                    babs_d  = b_mag;
                    rem_d   = '0;
                    count_d = '0;
                    busy_d  = 1'b1;
                    zdiv_d  = (bus.b == '0);
                    state_d = (bus.b == '0) ? FIX : CALC;
                end
            end
            CALC: begin
                // diff MSB set means the trial went negative: restore
                dvd_d   = {dvd_q[W-2:0], ~diff[N+1]};
                rem_d   = diff[N+1] ? shifted[N-1:0] : diff[N-1:0];
                count_d = count_q + 1'b1;
                if (count_q == CW'(W - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                if (zdiv_q) begin
                    // low N bits of the original dividend, rebuilt from its magnitude
                    q_d   = '1;
                    r_d   = sa_q ? dvd_neg[N-1:0] : dvd_q[N-1:0];
                    ovf_d = 1'b0;
                    dbz_d = 1'b1;
                end else begin
                    dbz_d = 1'b0;
                    ovf_d = q_ovf;
                    if (q_ovf) begin
                        q_d = q_neg ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
                    end else begin
                        q_d = q_neg ? dvd_neg[N-1:0] : dvd_q[N-1:0];
                    end
                    r_d = sa_q ? rem_neg : rem_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any division in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            dvd_q   <= '0;
            rem_q   <= '0;
            babs_q  <= '0;
            count_q <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            zdiv_q  <= 1'b0;
            q_q     <= '0;
            r_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            rem_q   <= rem_d;
            babs_q  <= babs_d;
            count_q <= count_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            zdiv_q  <= zdiv_d;
            q_q     <= q_d;
            r_q     <= r_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            dbz_q   <= dbz_d;
        end
    end

    assign bus.q    = q_q;
    assign bus.r    = r_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.ovf  = ovf_q;
    assign bus.dbz  = dbz_q;
endmodule

// File: tb/tb_div16s_seq.sv
// tb/tb_div16s_seq.sv - directed self-checking bench for div16s_seq
module tb_div16s_seq;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    div16s_seq_if #(.N(8)) ifc ();

    div16s_seq #(.N(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents operands with start for one accepting edge; returns 1 after that edge
    task automatic issue(input int av, input int bv);
        ifc.a     = 16'(av);
        ifc.b     = 8'(bv);
        ifc.start = 1'b1;
        step();
        ifc.start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!ifc.done && lat < 40) begin
            step();
            lat++;
        end
    endtask

    task automatic run_div(input string tag, input int av, input int bv, input int eq,
                           input int er, input int eovf, input int edbz, input int elat);
        int lat;
        issue(av, bv);
        wait_done(lat);
        check({tag, "_lat"}, lat, elat);
        check({tag, "_q"}, ifc.q, eq);
        check({tag, "_r"}, ifc.r, er);
        check({tag, "_ovf"}, ifc.ovf, eovf);
        check({tag, "_dbz"}, ifc.dbz, edbz);
        step();
        check({tag, "_done_pulse"}, ifc.done, 0);
        check({tag, "_q_hold"}, ifc.q, eq);
    endtask

    initial begin
        int lat;
        int dones;
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        ifc.start = 1'b0;
        ifc.a     = '0;
        ifc.b     = '0;
        step();
        step();
        check("rst_q", ifc.q, 0);
        check("rst_r", ifc.r, 0);
        check("rst_busy", ifc.busy, 0);
        check("rst_done", ifc.done, 0);
        check("rst_ovf", ifc.ovf, 0);
        check("rst_dbz", ifc.dbz, 0);
        rst = 1'b0;
        step();

        // basic: busy observed right after accept
        issue(100, 7);
        check("basic_busy", ifc.busy, 1);
        wait_done(lat);
        check("basic_lat", lat, 17);
        check("basic_q", ifc.q, 14);
        check("basic_r", ifc.r, 2);
        check("basic_busy_end", ifc.busy, 0);
        step();

        run_div("nn", -100, 7, -14, -2, 0, 0, 17);
        run_div("pn", 100, -7, -14, 2, 0, 0, 17);
        run_div("mm", -100, -7, 14, -2, 0, 0, 17);
        run_div("minq", -1024, 8, -128, 0, 0, 0, 17);
        run_div("ovfp", 1024, 8, 127, 0, 1, 0, 17);
        run_div("ovf_m1", -32768, -1, 127, 0, 1, 0, 17);
        run_div("ovf_m128", -32768, -128, 127, 0, 1, 0, 17);
        run_div("ovf_neg", 1000, -7, -128, 6, 1, 0, 17);
        run_div("dbz", 300, 0, -1, 44, 0, 1, 1);
        run_div("dbz_clr", 100, 7, 14, 2, 0, 0, 17);
        run_div("dbz_neg", -300, 0, -1, -44, 0, 1, 1);

        // start during CALC is ignored
        issue(100, 7);
        repeat (3) step();
        ifc.a     = 16'(5);
        ifc.b     = 8'(1);
        ifc.start = 1'b1;
        step();
        step();
        ifc.start = 1'b0;
        check("ign_busy", ifc.busy, 1);
        wait_done(lat);
        check("ign_lat", lat + 5, 17);
        check("ign_q", ifc.q, 14);
        check("ign_r", ifc.r, 2);

        // back-to-back: start in the done cycle
        step();
        issue(-100, 7);
        wait_done(lat);
        check("b2b1_q", ifc.q, -14);
        issue(1000, 9);
        check("b2b2_busy", ifc.busy, 1);
        wait_done(lat);
        check("b2b2_lat", lat, 17);
        check("b2b2_q", ifc.q, 111);
        check("b2b2_r", ifc.r, 1);
        step();

        // reset in the middle of CALC
        issue(100, 7);
        repeat (7) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_busy", ifc.busy, 0);
        check("mid_rst_done", ifc.done, 0);
        check("mid_rst_q", ifc.q, 0);
        check("mid_rst_r", ifc.r, 0);
        dones = 0;
        repeat (20) begin
            step();
            if (ifc.done) dones++;
        end
        check("mid_rst_no_done", dones, 0);
        run_div("post_rst", -1024, 8, -128, 0, 0, 0, 17);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
